// File: rtl/funrv32_pkg.sv
// funrv32_pkg: access-width codes (funct3[1:0]) and LSU state encoding shared by the LSU files
package funrv32_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} lsu_state_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane replication (LOAD=0) or load lane extraction with sign/zero extension (LOAD=1)
module lsu_align import funrv32_pkg::*; #(
  parameter bit LOAD = 1'b0
) (
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] din,
  output logic [31:0] dout
);
  logic [31:0] sh, ld, st;
  logic sb, shw;
  assign sh = din >> {off, 3'b000};
  assign sb = ~funct3[2] & sh[7];
  assign shw = ~funct3[2] & sh[15];
  assign ld = funct3[1:0] == SZ_B ? {{24{sb}}, sh[7:0]} :
              funct3[1:0] == SZ_H ? {{16{shw}}, sh[15:0]} : din;
  assign st = funct3[1:0] == SZ_B ? {4{din[7:0]}} :
              funct3[1:0] == SZ_H ? {2{din[15:0]}} : din;
  assign dout = LOAD ? ld : st;
endmodule

// File: rtl/lsu_dmem.sv
// lsu_dmem: RV32I load/store unit driving a 1-cycle-latency single-port data RAM.
// Define FUNRV32_LSU_FAULT_EN to fault misaligned accesses instead of force-aligning them.
module lsu_dmem import funrv32_pkg::*; #(
  parameter int ADDR_W = 14
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_store,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_valid,
  output logic [31:0]       o_rdata,
  output logic              o_fault,
  output logic              o_dm_ren,
  output logic              o_dm_wen,
  output logic [3:0]        o_dm_ben,
  output logic [ADDR_W-1:0] o_dm_addr,
  output logic [31:0]       o_dm_wdata,
  input  logic [31:0]       i_dm_rdata,
  input  logic              i_mem_ready
);
  lsu_state_e state, state_nx;
  logic r_store;
  logic [2:0] r_f3;
  logic [ADDR_W+1:0] r_addr;
  logic [31:0] r_wdata, r_rdata, st_data, ld_data;
  logic [1:0] off;
  logic [3:0] ben;
  logic unsup, mis, skip, go, unused;
  assign unused = ^i_addr[31:ADDR_W+2];
  assign unsup = r_f3[1:0] == 2'b11 || r_f3 == 3'b110;
  assign mis = (r_f3[1:0] == SZ_H && r_addr[0]) || (r_f3 == {1'b0, SZ_W} && r_addr[1:0] != 2'b00);
`ifdef FUNRV32_LSU_FAULT_EN
  assign skip = unsup | mis;
  assign off = r_addr[1:0];
`else
  assign skip = unsup;
  assign off = r_f3[1:0] == SZ_H ? {r_addr[1], 1'b0} : r_f3[1:0] == SZ_W ? 2'b00 : r_addr[1:0];
`endif
  assign ben = r_f3[1:0] == SZ_B ? 4'b0001 << off : r_f3[1:0] == SZ_H ? 4'b0011 << off : 4'b1111;
  assign go = state == ISSUE && i_mem_ready && !skip;
  lsu_align #(.LOAD(1'b0)) u_st (.funct3(r_f3), .off(off), .din(r_wdata), .dout(st_data));
  lsu_align #(.LOAD(1'b1)) u_ld (.funct3(r_f3), .off(off), .din(i_dm_rdata), .dout(ld_data));
  assign o_ready = state == IDLE;
  assign o_valid = state == DONE;
  assign o_fault = state == DONE && skip;
  assign o_rdata = r_rdata;
  assign o_dm_ren = go & ~r_store;
  assign o_dm_wen = go & r_store;
  assign o_dm_ben = go ? ben : 4'b0000;
  assign o_dm_addr = go ? r_addr[ADDR_W+1:2] : '0;
  assign o_dm_wdata = go ? st_data : 32'd0;
  always_comb begin
    state_nx = state == IDLE ? (i_valid ? ISSUE : IDLE) :
               state == ISSUE ? (skip ? DONE : !i_mem_ready ? ISSUE : r_store ? DONE : WAIT_RD) :
               state == WAIT_RD ? DONE : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      r_store <= 1'b0;
      r_f3 <= 3'b000;
      r_addr <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && i_valid) begin
        r_store <= i_store;
        r_f3 <= i_funct3;
        r_addr <= i_addr[ADDR_W+1:0];
        r_wdata <= i_wdata;
        r_rdata <= 32'd0;
      end
      if (state == WAIT_RD) r_rdata <= ld_data;
    end
  end
endmodule

// File: tb/tb_lsu_dmem.sv
// tb_lsu_dmem: directed checks of lsu_dmem against a behavioural 16-word SPRAM
module tb_lsu_dmem;
  logic i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_store = 1'b0, i_mem_ready = 1'b1;
  logic [2:0] i_funct3 = 3'b000;
  logic [31:0] i_addr = 32'd0, i_wdata = 32'd0, i_dm_rdata = 32'd0;
  logic o_ready, o_valid, o_fault, o_dm_ren, o_dm_wen;
  logic [31:0] o_rdata, o_dm_wdata;
  logic [3:0] o_dm_ben;
  logic [13:0] o_dm_addr;
  logic [31:0] mem [16];
  int ren_cnt = 0, wen_cnt = 0;
  logic [13:0] last_addr = '0;
  logic [3:0] last_ben = '0;
  logic [31:0] last_wdata = '0;
  int checks = 0, errors = 0;

  lsu_dmem #(.ADDR_W(14)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_store(i_store), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_valid(o_valid), .o_rdata(o_rdata), .o_fault(o_fault),
    .o_dm_ren(o_dm_ren), .o_dm_wen(o_dm_wen), .o_dm_ben(o_dm_ben),
    .o_dm_addr(o_dm_addr), .o_dm_wdata(o_dm_wdata), .i_dm_rdata(i_dm_rdata),
    .i_mem_ready(i_mem_ready)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_dm_ren) begin
      i_dm_rdata <= mem[o_dm_addr[3:0]];
      ren_cnt <= ren_cnt + 1;
      last_addr <= o_dm_addr;
    end
    if (o_dm_wen) begin
      for (int b = 0; b < 4; b++)
        if (o_dm_ben[b]) mem[o_dm_addr[3:0]][8*b +: 8] <= o_dm_wdata[8*b +: 8];
      wen_cnt <= wen_cnt + 1;
      last_addr <= o_dm_addr;
      last_ben <= o_dm_ben;
      last_wdata <= o_dm_wdata;
    end
  end

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic flt, output logic [31:0] rd);
    @(negedge i_clk);
    i_valid = 1'b1; i_store = st; i_funct3 = f3; i_addr = a; i_wdata = wd;
    @(posedge i_clk);
    #1 i_valid = 1'b0; i_store = 1'b0; i_funct3 = 3'b000; i_addr = 32'd0; i_wdata = 32'd0;
    lat = 0; flt = 1'bx; rd = 32'hxxxx_xxxx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge i_clk);
      if (o_valid) begin
        lat = n; flt = o_fault; rd = o_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({o_valid, o_fault, o_rdata, o_dm_ren, o_dm_wen, o_dm_ben, o_dm_addr, o_dm_wdata} !== '0) begin
      errors++; $display("FAIL reset_outputs got v=%b f=%b rd=%h ren=%b wen=%b ben=%b a=%h wd=%h need all 0",
                         o_valid, o_fault, o_rdata, o_dm_ren, o_dm_wen, o_dm_ben, o_dm_addr, o_dm_wdata);
    end
    @(negedge i_clk); i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b need 1", o_ready); end
  endtask

  task automatic test_store_word();
    int lat, w0; logic flt; logic [31:0] rd;
    w0 = wen_cnt;
    do_req(1'b1, 3'b010, 32'h0, 32'h8012_3456, lat, flt, rd);
    checks++;
    if ({lat, flt, rd} !== {32'd2, 1'b0, 32'd0}) begin
      errors++; $display("FAIL sw_done got lat=%0d f=%b rd=%h need lat=2 f=0 rd=0", lat, flt, rd);
    end
    checks++;
    if ({wen_cnt - w0, last_addr, last_ben, last_wdata} !== {32'd1, 14'h0, 4'b1111, 32'h8012_3456}) begin
      errors++; $display("FAIL sw_port got n=%0d a=%h ben=%b wd=%h need n=1 a=0 ben=1111 wd=80123456",
                         wen_cnt - w0, last_addr, last_ben, last_wdata);
    end
    do_req(1'b1, 3'b010, 32'h4, 32'h1234_8001, lat, flt, rd);
  endtask

  task automatic test_load();
    int lat, r0; logic flt; logic [31:0] rd;
    r0 = ren_cnt;
    do_req(1'b0, 3'b000, 32'h3, 32'h0, lat, flt, rd);
    checks++;
    if ({lat, flt, rd} !== {32'd3, 1'b0, 32'hFFFF_FF80}) begin
      errors++; $display("FAIL lb_sext got lat=%0d f=%b rd=%h need lat=3 f=0 rd=ffffff80", lat, flt, rd);
    end
    checks++;
    if (ren_cnt - r0 !== 1) begin errors++; $display("FAIL lb_ren_count got %0d need 1", ren_cnt - r0); end
    do_req(1'b0, 3'b100, 32'h3, 32'h0, lat, flt, rd);
    checks++;
    if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h need 00000080", rd); end
    do_req(1'b0, 3'b001, 32'h2, 32'h0, lat, flt, rd);
    checks++;
    if (rd !== 32'hFFFF_8012) begin errors++; $display("FAIL lh_hi got %h need ffff8012", rd); end
    do_req(1'b0, 3'b101, 32'h0, 32'h0, lat, flt, rd);
    checks++;
    if (rd !== 32'h0000_3456) begin errors++; $display("FAIL lhu_lo got %h need 00003456", rd); end
    do_req(1'b0, 3'b000, 32'h1, 32'h0, lat, flt, rd);
    checks++;
    if (rd !== 32'h0000_0034) begin errors++; $display("FAIL lb_lane1 got %h need 00000034", rd); end
    do_req(1'b0, 3'b001, 32'h4, 32'h0, lat, flt, rd);
    checks++;
    if (rd !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_word1 got %h need ffff8001", rd); end
    do_req(1'b0, 3'b010, 32'h4, 32'h0, lat, flt, rd);
    checks++;
    if ({rd, last_addr} !== {32'h1234_8001, 14'h1}) begin
      errors++; $display("FAIL lw got rd=%h a=%h need rd=12348001 a=0001", rd, last_addr);
    end
  endtask

  task automatic test_store_sub();
    int lat, w0; logic flt; logic [31:0] rd;
    w0 = wen_cnt;
    do_req(1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, lat, flt, rd);
    checks++;
    if ({lat, wen_cnt - w0, last_addr, last_ben, last_wdata} !== {32'd2, 32'd1, 14'h040, 4'b1100, 32'hBEEF_BEEF}) begin
      errors++; $display("FAIL sh_port got lat=%0d n=%0d a=%h ben=%b wd=%h need lat=2 n=1 a=0040 ben=1100 wd=beefbeef",
                         lat, wen_cnt - w0, last_addr, last_ben, last_wdata);
    end
    do_req(1'b0, 3'b010, 32'h0000_0100, 32'h0, lat, flt, rd);
    checks++;
    if (rd !== 32'hBEEF_3456) begin errors++; $display("FAIL sh_merge got %h need beef3456", rd); end
    do_req(1'b1, 3'b000, 32'h5, 32'h1111_22A7, lat, flt, rd);
    checks++;
    if ({last_ben, last_wdata} !== {4'b0010, 32'hA7A7_A7A7}) begin
      errors++; $display("FAIL sb_port got ben=%b wd=%h need ben=0010 wd=a7a7a7a7", last_ben, last_wdata);
    end
    do_req(1'b0, 3'b010, 32'h0001_0004, 32'h0, lat, flt, rd);
    checks++;
    if ({rd, last_addr} !== {32'h1234_A701, 14'h1}) begin
      errors++; $display("FAIL lw_wrap got rd=%h a=%h need rd=1234a701 a=0001", rd, last_addr);
    end
  endtask

  task automatic test_misalign();
    int lat, r0; logic flt; logic [31:0] rd;
    r0 = ren_cnt;
    do_req(1'b0, 3'b010, 32'h6, 32'h0, lat, flt, rd);
`ifdef FUNRV32_LSU_FAULT_EN
    checks++;
    if ({lat, flt, ren_cnt - r0} !== {32'd2, 1'b1, 32'd0}) begin
      errors++; $display("FAIL lw_misalign got lat=%0d f=%b ren=%0d need lat=2 f=1 ren=0", lat, flt, ren_cnt - r0);
    end
`else
    checks++;
    if ({lat, flt, ren_cnt - r0, last_addr, rd} !== {32'd3, 1'b0, 32'd1, 14'h1, 32'h1234_A701}) begin
      errors++; $display("FAIL lw_misalign got lat=%0d f=%b ren=%0d a=%h rd=%h need lat=3 f=0 ren=1 a=0001 rd=1234a701",
                         lat, flt, ren_cnt - r0, last_addr, rd);
    end
`endif
  endtask

  task automatic test_unsupported();
    int lat, r0, w0; logic flt; logic [31:0] rd;
    logic [2:0] f3s [3] = '{3'b111, 3'b011, 3'b110};
    for (int i = 0; i < 3; i++) begin
      r0 = ren_cnt; w0 = wen_cnt;
      do_req(i == 1, f3s[i], 32'h0, 32'h0, lat, flt, rd);
      checks++;
      if ({lat, flt, ren_cnt - r0, wen_cnt - w0} !== {32'd2, 1'b1, 32'd0, 32'd0}) begin
        errors++; $display("FAIL unsup_%b got lat=%0d f=%b ren=%0d wen=%0d need lat=2 f=1 ren=0 wen=0",
                           f3s[i], lat, flt, ren_cnt - r0, wen_cnt - w0);
      end
    end
  endtask

  task automatic test_mem_stall();
    int lat, r0; logic bad; logic [31:0] rd;
    r0 = ren_cnt; bad = 1'b0; lat = 0; rd = 32'd0;
    @(negedge i_clk);
    i_mem_ready = 1'b0; i_valid = 1'b1; i_funct3 = 3'b010; i_addr = 32'h4;
    @(posedge i_clk);
    #1 i_valid = 1'b0; i_addr = 32'd0;
    for (int n = 0; n < 5; n++) begin
      @(negedge i_clk);
      if (o_dm_ren || o_dm_wen || o_valid) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL stall_quiet got strobe/valid during stall need none"); end
    @(posedge i_clk);
    #1 i_mem_ready = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge i_clk);
      if (o_valid) begin lat = n; rd = o_rdata; break; end
    end
    checks++;
    if ({lat, rd, ren_cnt - r0} !== {32'd3, 32'h1234_A701, 32'd1}) begin
      errors++; $display("FAIL stall_done got lat=%0d rd=%h ren=%0d need lat=3 rd=1234a701 ren=1", lat, rd, ren_cnt - r0);
    end
  endtask

  task automatic test_reset_midway();
    int r0; logic bad;
    r0 = ren_cnt; bad = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b1; i_funct3 = 3'b010; i_addr = 32'h4;
    @(posedge i_clk);
    #1 i_valid = 1'b0; i_addr = 32'd0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_rdata, o_dm_ren, o_dm_wen, o_dm_ben} !== '0) begin
      errors++; $display("FAIL midrst_async got v=%b rd=%h ren=%b wen=%b ben=%b need all 0",
                         o_valid, o_rdata, o_dm_ren, o_dm_wen, o_dm_ben);
    end
    @(negedge i_clk); i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b need 1", o_ready); end
    for (int n = 0; n < 4; n++) begin
      if (o_valid) bad = 1'b1;
      @(negedge i_clk);
    end
    checks++;
    if ({bad, ren_cnt - r0} !== {1'b0, 32'd1}) begin
      errors++; $display("FAIL midrst_abandon got valid_seen=%b ren=%0d need 0 and 1", bad, ren_cnt - r0);
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load();
    test_store_sub();
    test_misalign();
    test_unsupported();
    test_mem_stall();
    test_reset_midway();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
